// File: rtl/pwm_compare.sv
// pwm_compare: owns the counter period and duty (double-buffered, applied on wrap) and drives a registered PWM.
// Optional build macro PWM_COMPARE_IRQ_EN adds a sticky irq flag (irq/irq_clr) set on each configuration update.
module pwm_compare #(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_MAX = '1,
  parameter logic [WIDTH-1:0] RST_DTY = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] cnt,
  input  logic             pls,
  output logic [WIDTH-1:0] max,
  input  logic             cfg_vld,
  output logic             cfg_rdy,
  input  logic [WIDTH-1:0] cfg_max,
  input  logic [WIDTH-1:0] cfg_dty,
  output logic             upd,
  output logic             pwm
`ifdef PWM_COMPARE_IRQ_EN
  ,
  output logic             irq,
  input  logic             irq_clr
`endif
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] act_max_q, act_max_d;
  logic [WIDTH-1:0] act_dty_q, act_dty_d;
  logic [WIDTH-1:0] pnd_max_q, pnd_max_d;
  logic [WIDTH-1:0] pnd_dty_q, pnd_dty_d;
  logic             upd_q, upd_d;
  logic             pwm_q, pwm_d;
  logic             xfer_s, apply_s;

  // Apply is qualified by ena too, so a stray pulse while stalled can never swap the period.
  assign xfer_s  = cfg_vld & (state_q == ST_EMPTY);
  assign apply_s = pls & ena & (state_q == ST_FULL);

  // Pending-slot state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Pending-slot next state: fill on transfer, drain on wrap
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (xfer_s) begin
          state_d = ST_FULL;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (apply_s) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Pending-slot output decode
  always_comb begin
    cfg_rdy = 1'b0;
    case (state_q)
      ST_EMPTY: cfg_rdy = 1'b1;
      ST_FULL:  cfg_rdy = 1'b0;
      default:  cfg_rdy = 1'b0;
    endcase
  end

  // Datapath next values: capture on transfer, promote pending to active on wrap
  always_comb begin
    pnd_max_d = pnd_max_q;
    pnd_dty_d = pnd_dty_q;
    act_max_d = act_max_q;
    act_dty_d = act_dty_q;
    if (xfer_s) begin
      pnd_max_d = cfg_max;
      pnd_dty_d = cfg_dty;
    end else begin
      pnd_max_d = pnd_max_q;
      pnd_dty_d = pnd_dty_q;
    end
    if (apply_s) begin
      act_max_d = pnd_max_q;
      act_dty_d = pnd_dty_q;
    end else begin
      act_max_d = act_max_q;
      act_dty_d = act_dty_q;
    end
    upd_d = apply_s;
    pwm_d = (cnt < act_dty_q);
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pnd_max_q <= {WIDTH{1'b0}};
      pnd_dty_q <= {WIDTH{1'b0}};
      act_max_q <= RST_MAX;
      act_dty_q <= RST_DTY;
      upd_q     <= 1'b0;
      pwm_q     <= 1'b0;
    end else begin
      pnd_max_q <= pnd_max_d;
      pnd_dty_q <= pnd_dty_d;
      act_max_q <= act_max_d;
      act_dty_q <= act_dty_d;
      upd_q     <= upd_d;
      pwm_q     <= pwm_d;
    end
  end

  assign max = act_max_q;
  assign upd = upd_q;
  assign pwm = pwm_q;

`ifdef PWM_COMPARE_IRQ_EN
  logic irq_q, irq_d;

  // Sticky update flag; a set on the same edge as a clear takes priority
  always_comb begin
    irq_d = irq_q;
    if (apply_s) begin
      irq_d = 1'b1;
    end else if (irq_clr) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  // Update flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_pwm_compare.sv
// Self-checking bench for pwm_compare (WIDTH=8): a queue-based reference model plus a wrap-on-max
// counter drive the DUT; table-driven duty checks, hand-written corner sequences and random traffic.
module tb_pwm_compare;

  typedef struct {
    logic [7:0] mx;
    logic [7:0] dt;
  } cfg_t;

  typedef struct {
    logic [7:0] mx;
    logic [7:0] dt;
    int         exp_hi;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] cnt;
  logic       pls;
  logic [7:0] max_o;
  logic       cfg_vld;
  logic       cfg_rdy;
  logic [7:0] cfg_max;
  logic [7:0] cfg_dty;
  logic       upd;
  logic       pwm;
  logic       irq_clr;
`ifdef PWM_COMPARE_IRQ_EN
  logic       irq;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  cfg_t       pend[$];
  logic [7:0] m_max;
  logic [7:0] m_dty;
  logic       m_upd;
  logic       m_pwm;
  logic       m_irq;
  logic [7:0] ctr_max;

  vec_t tbl[7];

  pwm_compare #(.WIDTH(8), .RST_MAX(8'hFF), .RST_DTY(8'h00)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .cnt     (cnt),
    .pls     (pls),
    .max     (max_o),
    .cfg_vld (cfg_vld),
    .cfg_rdy (cfg_rdy),
    .cfg_max (cfg_max),
    .cfg_dty (cfg_dty),
    .upd     (upd),
    .pwm     (pwm)
`ifdef PWM_COMPARE_IRQ_EN
    ,
    .irq     (irq),
    .irq_clr (irq_clr)
`endif
  );

  always #5 clk = ~clk;

  // Counter wrap pulse: enabled and at the active period's last count
  assign pls = ena && (cnt == ctr_max);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    m_max   = 8'hFF;
    m_dty   = 8'h00;
    m_upd   = 1'b0;
    m_pwm   = 1'b0;
    m_irq   = 1'b0;
    cnt     = 8'h00;
    ctr_max = 8'hFF;
  endtask

  // One clock: advance the model with the inputs seen at the rising edge, move the counter,
  // then compare every DUT output against the model.
  task automatic tick();
    logic wrap;
    logic take;
    cfg_t c;
    @(negedge clk);
    wrap  = pls;
    take  = (pend.size() == 0);
    m_pwm = (cnt < m_dty);
    m_upd = 1'b0;
    if (irq_clr) m_irq = 1'b0;
    if (wrap && !take) begin
      c     = pend.pop_front();
      m_max = c.mx;
      m_dty = c.dt;
      m_upd = 1'b1;
      m_irq = 1'b1;
    end
    if (cfg_vld && take) pend.push_back('{cfg_max, cfg_dty});
    if (ena) cnt = wrap ? 8'h00 : cnt + 8'h01;
    ctr_max = m_max;
    check("max", 32'(max_o), 32'(m_max));
    check("cfg_rdy", 32'(cfg_rdy), 32'(pend.size() == 0));
    check("upd", 32'(upd), 32'(m_upd));
    check("pwm", 32'(pwm), 32'(m_pwm));
`ifdef PWM_COMPARE_IRQ_EN
    check("irq", 32'(irq), 32'(m_irq));
`endif
  endtask

  task automatic wait_upd(input int bound, input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      tick();
      if (upd) seen = 1'b1;
    end
    check(nm, 32'(seen), 32'd1);
  endtask

  task automatic wait_pls(input int bound, input string nm);
    bit seen;
    seen = pls;
    for (int i = 0; i < bound && !seen; i++) begin
      tick();
      if (pls) seen = 1'b1;
    end
    check(nm, 32'(seen), 32'd1);
  endtask

  task automatic load(input logic [7:0] mx, input logic [7:0] dt);
    cfg_max = mx;
    cfg_dty = dt;
    cfg_vld = 1'b1;
    tick();
    cfg_vld = 1'b0;
    check("rdy_after_xfer", 32'(cfg_rdy), 32'd0);
  endtask

  initial begin
    int hi;
    int nupd;
    tbl[0] = '{8'd9,  8'd3,  3};
    tbl[1] = '{8'd9,  8'd10, 10};
    tbl[2] = '{8'd9,  8'd9,  9};
    tbl[3] = '{8'd4,  8'd2,  2};
    tbl[4] = '{8'd0,  8'd1,  1};
    tbl[5] = '{8'd15, 8'd16, 16};
    tbl[6] = '{8'd9,  8'd0,  0};

    rst = 1'b1; ena = 1'b0; cfg_vld = 1'b0; cfg_max = 8'h00; cfg_dty = 8'h00; irq_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_max", 32'(max_o), 32'hFF);
    check("rst_rdy", 32'(cfg_rdy), 32'd1);
    check("rst_upd", 32'(upd), 32'd0);
    check("rst_pwm", 32'(pwm), 32'd0);
    rst = 1'b0;

    // Reset duty of zero keeps pwm low
    ena = 1'b1;
    hi = 0;
    repeat (300) begin
      tick();
      hi += int'(pwm);
    end
    check("dty0_hi", 32'(hi), 32'd0);

    // Duty table: high count over one full period after the update lands
    for (int i = 0; i < 7; i++) begin
      load(tbl[i].mx, tbl[i].dt);
      wait_upd(600, "tbl_upd");
      check("tbl_max", 32'(max_o), 32'(tbl[i].mx));
      hi = 0;
      for (int k = 0; k <= int'(tbl[i].mx); k++) begin
        tick();
        hi += int'(pwm);
      end
      check("tbl_hi", 32'(hi), 32'(tbl[i].exp_hi));
    end

    // pwm rises the cycle after cnt=0 with max=9, dty=3
    load(8'd9, 8'd3);
    wait_upd(40, "rise_upd");
    check("rise_n0", 32'(pwm), 32'd0);
    tick(); check("rise_n1", 32'(pwm), 32'd1);
    tick(); check("rise_n2", 32'(pwm), 32'd1);
    tick(); check("rise_n3", 32'(pwm), 32'd1);
    tick(); check("rise_n4", 32'(pwm), 32'd0);

    // Backpressure: second entry held valid while pending, accepted in the upd cycle
    cfg_max = 8'd5; cfg_dty = 8'd1; cfg_vld = 1'b1;
    tick();
    cfg_max = 8'd4; cfg_dty = 8'd2;
    check("bp_rdy_low", 32'(cfg_rdy), 32'd0);
    wait_upd(40, "bp_upd1");
    check("bp_max5", 32'(max_o), 32'd5);
    check("bp_rdy_upd", 32'(cfg_rdy), 32'd1);
    tick();
    cfg_vld = 1'b0;
    check("bp_accepted", 32'(cfg_rdy), 32'd0);
    wait_upd(40, "bp_upd2");
    check("bp_max4", 32'(max_o), 32'd4);
    hi = 0;
    repeat (5) begin
      tick();
      hi += int'(pwm);
    end
    check("bp_hi", 32'(hi), 32'd2);

    // Race: transfer on the same edge as the wrap goes to pending only
    wait_pls(20, "race_pls");
    cfg_max = 8'd7; cfg_dty = 8'd3; cfg_vld = 1'b1;
    tick();
    cfg_vld = 1'b0;
    check("race_no_upd", 32'(upd), 32'd0);
    check("race_max_old", 32'(max_o), 32'd4);
    check("race_rdy", 32'(cfg_rdy), 32'd0);
    wait_upd(40, "race_upd");
    check("race_max7", 32'(max_o), 32'd7);

    // Stall: pending entry is not applied while ena is low
    load(8'd6, 8'd2);
    ena = 1'b0;
    nupd = 0;
    repeat (100) begin
      tick();
      nupd += int'(upd);
    end
    check("stall_no_upd", 32'(nupd), 32'd0);
    check("stall_rdy", 32'(cfg_rdy), 32'd0);
    ena = 1'b1;
    wait_upd(40, "stall_upd");
    check("stall_max6", 32'(max_o), 32'd6);

`ifdef PWM_COMPARE_IRQ_EN
    // Sticky irq: clear works alone; set wins over a coincident clear
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    check("irq_clr", 32'(irq), 32'd0);
    load(8'd8, 8'd4);
    wait_pls(20, "irq_pls");
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    check("irq_upd", 32'(upd), 32'd1);
    check("irq_set_wins", 32'(irq), 32'd1);
`endif

    // Reset while an entry is pending: everything returns to reset values immediately
    load(8'd3, 8'd1);
    #1 rst = 1'b1;
    model_reset();
    #1;
    check("mid_rst_rdy", 32'(cfg_rdy), 32'd1);
    check("mid_rst_max", 32'(max_o), 32'hFF);
    check("mid_rst_upd", 32'(upd), 32'd0);
    check("mid_rst_pwm", 32'(pwm), 32'd0);
    #1 rst = 1'b0;
    repeat (20) tick();
    check("mid_rst_max_hold", 32'(max_o), 32'hFF);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      ena     = ($urandom_range(0, 9) != 0);
      cfg_vld = ($urandom_range(0, 3) == 0);
      cfg_max = 8'($urandom_range(0, 20));
      cfg_dty = 8'($urandom_range(0, 22));
      irq_clr = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
